// File: rtl/sound_mixer_n.sv
// sound_mixer_n: time-multiplexed N-channel audio mixer with CPU-writable
// per-channel gains, output-latch muting and a saturating output stage.
// One multiply-accumulate per clk after each sample strobe.
module sound_mixer_n #(
   parameter int          NUM_CH     = 4,
   parameter int          IN_W       = 4,
   parameter int          GAIN_W     = 4,
   parameter int          OUT_W      = 16,
   parameter int          OUT_SHIFT  = 6,
   parameter logic [15:0] BASE_ADDR  = 16'h1850,
   parameter int          GAIN_RESET = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_48KHz_en,
   input  logic [15:0]              addr_to_bram,
   input  logic [7:0]               data_to_bram,
   input  logic                     should_read,
   input  logic                     bus_cyc,
   output logic [7:0]               data_from_mixer,
   input  logic [NUM_CH*IN_W-1:0]   chan_audio,
   input  logic [NUM_CH-1:0]        mute_mask,
   output logic [OUT_W-1:0]         audio,
   output logic                     sample_valid,
   output logic                     busy,
   output logic                     overrun
);

   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PROD_W = IN_W + GAIN_W;
   localparam int ACC_W  = IN_W + GAIN_W + $clog2(NUM_CH) + 1;
   localparam int SH_W   = ACC_W + OUT_SHIFT;
   localparam int WIDE_W = ((SH_W > OUT_W) ? SH_W : OUT_W) + 1;
   localparam logic [WIDE_W-1:0] MAX_OUT = (WIDE_W'(1) << OUT_W) - WIDE_W'(1);

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   state_t               state, state_next;
   logic [GAIN_W-1:0]    gain      [NUM_CH];
   logic [GAIN_W-1:0]    sh_gain   [NUM_CH];
   logic [IN_W-1:0]      sh_sample [NUM_CH];
   logic [NUM_CH-1:0]    sh_mute;
   logic [ACC_W-1:0]     acc;
   logic [IDX_W-1:0]     idx;
   logic [PROD_W-1:0]    product;
   logic [WIDE_W-1:0]    shifted;
   logic [OUT_W-1:0]     audio_sat;
   logic [15:0]          offset;
   logic                 bus_wr;
   logic                 status_wr;
   logic                 start;

   // Register decode: offset from the base selects gain[k] or the status word.
   assign offset    = addr_to_bram - BASE_ADDR;
   assign bus_wr    = bus_cyc && !should_read;
   assign status_wr = bus_wr && (offset == 16'(NUM_CH));
   assign busy      = (state != IDLE);
   assign start     = clk_48KHz_en && (state == IDLE);

   // Gain registers: CPU writes take effect immediately; the mix uses shadows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) gain[k] <= GAIN_W'(GAIN_RESET);
      end else begin
         for (int k = 0; k < NUM_CH; k++)
            if (bus_wr && (offset == 16'(k))) gain[k] <= data_to_bram[GAIN_W-1:0];
      end
   end

   // CPU read mux, combinational from the current registers.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      data_from_mixer = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (bus_cyc && (offset == 16'(k))) data_from_mixer = 8'(gain[k]);
      if (bus_cyc && (offset == 16'(NUM_CH))) data_from_mixer = {6'b0, busy, overrun};
   end

   // Frame snapshot of samples, mutes and gains, taken on an accepted strobe.
   // NOTE: shadows carry no reset; they are always loaded before ACCUM reads them.
   always_ff @(posedge clk) begin
      if (start) begin
         sh_mute <= mute_mask;
         for (int k = 0; k < NUM_CH; k++) begin
            sh_sample[k] <= chan_audio[k*IN_W +: IN_W];
            sh_gain[k]   <= gain[k];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: one MAC per clk, then one output cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (clk_48KHz_en) state_next = ACCUM;
         ACCUM:   if (idx == IDX_W'(NUM_CH - 1)) state_next = OUTPUT;
         OUTPUT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Current channel's contribution; a muted channel adds zero.
   always_comb begin
      product = '0;
      if (!sh_mute[idx]) product = PROD_W'(sh_sample[idx]) * PROD_W'(sh_gain[idx]);
   end

   // Output stage: shift, then clamp to full scale (the accumulator never wraps).
   assign shifted   = WIDE_W'(acc) << OUT_SHIFT;
   assign audio_sat = (shifted > MAX_OUT) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

   // Datapath: accumulator, channel index, output word, valid pulse, overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc          <= '0;
         idx          <= '0;
         audio        <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (clk_48KHz_en) begin
                  acc <= '0;
                  idx <= '0;
               end
            end
            ACCUM: begin
               acc <= acc + ACC_W'(product);
               idx <= idx + IDX_W'(1);
            end
            OUTPUT: begin
               audio        <= audio_sat;
               sample_valid <= 1'b1;
            end
            default: ;
         endcase
         // Setting wins over a coincident clear from a status write.
         if (clk_48KHz_en && busy) overrun <= 1'b1;
         else if (status_wr)       overrun <= 1'b0;
      end
   end

endmodule

// File: doc/sound_mixer_n.md
Name: sound_mixer_n

Overview:
- Parametrised N-channel audio mixer for the sound subsystem.
- Combines several 4-bit POKEY-style channel outputs and discrete-sound channels into one unsigned audio word.
- Each channel has a CPU-writable gain register. Channels can also be muted by output-latch bits.
- Mixing is time-multiplexed: one multiply-accumulate per clk after each sample strobe. This replaces fixed single-POKEY summing and supports multi-POKEY boards.

Parameters:
- NUM_CH, 4, number of input channels (1..16).
- IN_W, 4, bits per channel sample (unsigned).
- GAIN_W, 4, bits per gain register (unsigned).
- OUT_W, 16, output audio width.
- OUT_SHIFT, 6, left shift applied to the accumulator before saturation.
- BASE_ADDR, 16'h1850, CPU address of gain register 0.
- GAIN_RESET, 15, reset value of every gain register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clk_48KHz_en  in  1  sample strobe, one-clk pulse
- addr_to_bram  in  16  CPU address
- data_to_bram  in  8  CPU write data
- should_read  in  1  1 = CPU read cycle, 0 = write cycle
- bus_cyc  in  1  CPU cycle strobe (one clk per access)
- data_from_mixer  out  8  CPU read data
- chan_audio  in  NUM_CH*IN_W  channel samples; channel i is at [i*IN_W +: IN_W]
- mute_mask  in  NUM_CH  1 = channel i muted (driven from output latch)
- audio  out  OUT_W  mixed audio
- sample_valid  out  1  one-clk pulse when audio updates
- busy  out  1  high while a mix is in progress
- overrun  out  1  sticky: a strobe arrived while busy

Behaviour:
- Reset (async, immediate) sets:
  - audio = 0, sample_valid = 0, busy = 0, overrun = 0
  - state = IDLE, accumulator = 0, channel index = 0
  - all gains = GAIN_RESET[GAIN_W-1:0]
- Register map, decoded on bus_cyc && addr_to_bram == BASE_ADDR+k:
  - k < NUM_CH: gain[k]. A write stores data_to_bram[GAIN_W-1:0]. A read returns the gain zero-extended to 8 bits.
  - k == NUM_CH: status. A read returns {6'b0, busy, overrun}. Any write clears overrun.
  - All other addresses: no effect; data_from_mixer = 0.
- data_from_mixer is combinational from the current registers.
- Widths:
  - product = IN_W+GAIN_W bits, unsigned.
  - ACC_W = IN_W+GAIN_W+clog2(NUM_CH)+1.
  - Muted channel contributes 0.
- FSM: IDLE -> ACCUM -> OUTPUT -> IDLE.
  - IDLE:
    - busy = 0.
    - On clk_48KHz_en: snapshot chan_audio, mute_mask and all gains into shadow registers; acc = 0; idx = 0; go to ACCUM.
  - ACCUM:
    - busy = 1.
    - Each clk: acc += (shadow_mute[idx] ? 0 : shadow_sample[idx]*shadow_gain[idx]); idx++.
    - After the edge that accumulates idx == NUM_CH-1, go to OUTPUT.
  - OUTPUT:
    - busy = 1.
    - Next edge: audio = min(acc << OUT_SHIFT, 2^OUT_W-1); sample_valid = 1 for exactly that one clk; go to IDLE.
- Latency: strobe edge E0; accumulation on edges E1..E_NUM_CH; audio and sample_valid update on E_(NUM_CH+1). audio holds between updates.
- Strobe while busy (ACCUM or OUTPUT): ignored, the in-flight mix completes unaffected, overrun is set.
- Strobe on the same edge as the return to IDLE (the OUTPUT edge): counts as busy, so overrun is set.
- Gain write during ACCUM: the register updates immediately, but the current mix uses its shadow value. The new gain applies from the next frame.
- Status write coincident with the overrun-setting event: set wins.
- Read cycles (should_read = 1) never modify any state.
- Reset mid-mix: the frame is abandoned; audio returns to 0; the next strobe starts a fresh mix.
- Saturation: the clamp is applied only at output. The accumulator itself never wraps, guaranteed by ACC_W.

Test Plan:
- Reset, no writes; chan_audio = {4'hF,4'hF,4'hF,4'hF}; strobe -> after 5 clks audio = 900<<6 = 16'd57600, sample_valid high for 1 clk, busy high for clks 1..5.
- Write gain[1] = 0 at 16'h1851; gain[2] = 8 at 16'h1852; read back 16'h1852 = 8'h08; channels = 3,5,2,1 with gains 15,0,8,15 -> audio = (45+0+16+15)<<6 = 4864.
- mute_mask = 4'b0101, all channels = 4'hA, default gains -> audio = (2*150)<<6 = 19200; mute_mask = 4'hF -> audio = 0.
- OUT_SHIFT = 8 build, all inputs = 15, gains = 15 -> 900<<8 = 230400 saturates, audio = 16'hFFFF.
- Strobe at E0 and again at E2 -> single sample_valid at E5, overrun = 1, status read = 8'h01; write 16'h1854 -> overrun = 0.
- Gain write to gain[0] at E2 of a mix -> that frame uses the old gain and the next frame uses the new one. Assert rst at E3 -> audio = 0, busy = 0 immediately, gains = 15.
